// File: rtl/dlog_ctrl_if.sv
// Bus bundle for dlog_ctrl: configuration, arm/disarm, commit observation and logging-state outputs.
// The slave modport is the controller side; the master modport is the driving/observing side.
interface dlog_ctrl_if #(
   parameter int unsigned CNT_W      = 64,
   parameter int unsigned WIN_W      = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned COMMIT_NUM = 4
);
   logic                         cfg_we;
   logic [CNT_W-1:0]             cfg_start;
   logic [WIN_W-1:0]             cfg_window;
   logic [1:0]                   cfg_level;
   logic                         arm;
   logic                         disarm;
   logic [COMMIT_NUM-1:0]        commit_valid;
   logic [COMMIT_NUM*ADDR_W-1:0] commit_pc;
   logic [ADDR_W-1:0]            trig_addr;
   logic [CNT_W-1:0]             cycle_cnt;
   logic                         log_valid;
   logic [1:0]                   log_level;
   logic [1:0]                   state;
   logic [CNT_W-1:0]             trig_cycle;
   logic [WIN_W-1:0]             log_cnt;

   modport master (
      output cfg_we, cfg_start, cfg_window, cfg_level, arm, disarm,
             commit_valid, commit_pc, trig_addr,
      input  cycle_cnt, log_valid, log_level, state, trig_cycle, log_cnt
   );

   modport slave (
      input  cfg_we, cfg_start, cfg_window, cfg_level, arm, disarm,
             commit_valid, commit_pc, trig_addr,
      output cycle_cnt, log_valid, log_level, state, trig_cycle, log_cnt
   );
endinterface

// File: rtl/dlog_ctrl.sv
// Global log/perf control: free-running cycle count, logging window FSM and log level.
// Define DLOG_TRIG_ADDR_EN to additionally gate the trigger on a committed-PC match.
module dlog_ctrl #(
   parameter int unsigned CNT_W      = 64,
   parameter int unsigned WIN_W      = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned COMMIT_NUM = 4
) (
   input  logic        clk,
   input  logic        rst,
   dlog_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_ACTIVE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_start;
   logic [CNT_W-1:0] r_trig_cycle;
   logic [WIN_W-1:0] r_window;
   logic [WIN_W-1:0] r_log_cnt;
   logic [1:0]       r_level;
   logic             r_log_valid;
   logic             w_pc_match;
   logic             w_trigger;
   logic             w_win_end;

`ifdef DLOG_TRIG_ADDR_EN
   // Any valid commit lane retiring the trigger PC this cycle.
   always_comb begin
      w_pc_match = 1'b0;
      for (int unsigned i = 0; i < COMMIT_NUM; i++) begin
         if (bus.commit_valid[i] && (bus.commit_pc[i*ADDR_W +: ADDR_W] == bus.trig_addr)) begin
            w_pc_match = 1'b1;
         end
      end
   end
`else
   logic w_unused_commit;
   assign w_unused_commit = ^{bus.commit_valid, bus.commit_pc, bus.trig_addr};
   assign w_pc_match      = 1'b1;
`endif

   // Plain unsigned compare: a wrapped cycle counter is not corrected for.
   assign w_trigger = (r_cycle_cnt >= r_start) && w_pc_match;
   assign w_win_end = (r_window != '0) && (r_log_cnt == (r_window - WIN_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state; disarm overrides every other transition.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (bus.arm)   w_next_state = S_ARMED;
         S_ARMED:  if (w_trigger) w_next_state = S_ACTIVE;
         S_ACTIVE: if (w_win_end) w_next_state = S_DONE;
         S_DONE:   w_next_state = S_DONE;
         default:  w_next_state = S_IDLE;
      endcase
      if (bus.disarm) begin
         w_next_state = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle_cnt  <= '0;
         r_start      <= '0;
         r_window     <= '0;
         r_level      <= '0;
         r_log_valid  <= 1'b0;
         r_trig_cycle <= '0;
         r_log_cnt    <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         r_log_valid <= (w_next_state == S_ACTIVE);
         if ((r_state == S_IDLE) && bus.cfg_we) begin
            r_start  <= bus.cfg_start;
            r_window <= bus.cfg_window;
            r_level  <= bus.cfg_level;
         end
         // Window counter: restart on trigger, clear on return to IDLE, saturate otherwise.
         if ((r_state == S_ARMED) && (w_next_state == S_ACTIVE)) begin
            r_trig_cycle <= r_cycle_cnt;
            r_log_cnt    <= '0;
         end else if (w_next_state == S_IDLE) begin
            r_log_cnt <= '0;
         end else if (r_log_valid && (r_log_cnt != '1)) begin
            r_log_cnt <= r_log_cnt + WIN_W'(1);
         end
      end
   end

   assign bus.cycle_cnt  = r_cycle_cnt;
   assign bus.log_valid  = r_log_valid;
   assign bus.log_level  = r_level;
   assign bus.state      = r_state;
   assign bus.trig_cycle = r_trig_cycle;
   assign bus.log_cnt    = r_log_cnt;

endmodule
